// File: rtl/alu_muldiv_pkg.sv
// Shared types for alu_muldiv: opcode and FSM state encodings, plus the
// decode helper that separates the M-extension group from the basic ALU ops.
// Related build macro: ALU_MULDIV_M_EN (selects the iterative unit in the top).
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_AND    = 5'h02,
    OP_OR     = 5'h03,
    OP_XOR    = 5'h04,
    OP_SLT    = 5'h05,
    OP_SRL    = 5'h06,
    OP_SRA    = 5'h07,
    OP_SLL    = 5'h08,
    OP_SLTU   = 5'h09,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Which slice of the iterative unit's work becomes the result.
  typedef enum logic [1:0] {
    SEL_LO  = 2'd0,
    SEL_HI  = 2'd1,
    SEL_QUO = 2'd2,
    SEL_REM = 2'd3
  } it_sel_e;

  // Opcodes 0x10..0x17 form the multiply/divide group.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op[4:3] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/response bundle for alu_muldiv. The master side issues operations
// and consumes results; the slave side is the ALU itself.
interface alu_muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      ALUControl;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [XLEN-1:0] ALUOut;
  logic            Zero;
  logic            less;
  logic            illegal;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in_valid, ALUControl, A, B, out_ready,
    input  in_ready, ALUOut, Zero, less, illegal, out_valid
  );

  modport slave (
    input  in_valid, ALUControl, A, B, out_ready,
    output in_ready, ALUOut, Zero, less, illegal, out_valid
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiply/divide engine. A start strobe loads sign-stripped
// operand magnitudes; one shift-add (multiply) and one restoring step
// (divide) run each cycle. On the XLEN-th step the final value is taken
// straight from the step logic so the caller can register it the same cycle
// that done is high. Signs are reapplied on the way out. Operand pairs that
// need no iteration (divide by zero, signed overflow) never reach this unit.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] x);
    return '0 - x;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2w(input logic [2*XLEN-1:0] x);
    return '0 - x;
  endfunction

  logic            busy;
  logic [CW-1:0]   cnt;

  logic            a_sgn, b_sgn;
  it_sel_e         sel_c;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [2*XLEN-1:0] prod_p0;
  logic [XLEN-1:0]   mcand_p0;
  logic [XLEN-1:0]   rem_p0;
  logic [XLEN-1:0]   quo_p0;
  logic [XLEN-1:0]   dvs_p0;
  logic              neg_res_p0;
  logic              neg_rem_p0;
  it_sel_e           sel_p0;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_nxt;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   rem_diff;
  logic [XLEN-1:0]   rem_nxt;
  logic [XLEN-1:0]   quo_nxt;
  logic [2*XLEN-1:0] prod_fin;

  // Operand signedness and result slice for the requested opcode.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    sel_c = SEL_LO;
    case (op)
      OP_MUL:    sel_c = SEL_LO;
      OP_MULH:   begin sel_c = SEL_HI;  a_sgn = a[XLEN-1]; b_sgn = b[XLEN-1]; end
      OP_MULHSU: begin sel_c = SEL_HI;  a_sgn = a[XLEN-1]; end
      OP_MULHU:  sel_c = SEL_HI;
      OP_DIV:    begin sel_c = SEL_QUO; a_sgn = a[XLEN-1]; b_sgn = b[XLEN-1]; end
      OP_DIVU:   sel_c = SEL_QUO;
      OP_REM:    begin sel_c = SEL_REM; a_sgn = a[XLEN-1]; b_sgn = b[XLEN-1]; end
      OP_REMU:   sel_c = SEL_REM;
      default:   sel_c = SEL_LO;
    endcase
    a_mag = a_sgn ? neg_w(a) : a;
    b_mag = b_sgn ? neg_w(b) : b;
  end

  // One multiply step and one restoring-divide step from the current state.
  always_comb begin
    mul_sum  = {1'b0, prod_p0[2*XLEN-1:XLEN]} + (prod_p0[0] ? {1'b0, mcand_p0} : '0);
    prod_nxt = {mul_sum, prod_p0[XLEN-1:1]};
    rem_sh   = {rem_p0, quo_p0[XLEN-1]};
    rem_diff = {1'b0, rem_sh} - {2'b00, dvs_p0};
    if (!rem_diff[XLEN+1]) begin
      rem_nxt = rem_diff[XLEN-1:0];
      quo_nxt = {quo_p0[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[XLEN-1:0];
      quo_nxt = {quo_p0[XLEN-2:0], 1'b0};
    end
  end

  // Sign restoration and slice selection on the final step.
  always_comb begin
    prod_fin = neg_res_p0 ? neg_2w(prod_nxt) : prod_nxt;
    case (sel_p0)
      SEL_LO:  result = prod_fin[XLEN-1:0];
      SEL_HI:  result = prod_fin[2*XLEN-1:XLEN];
      SEL_QUO: result = neg_res_p0 ? neg_w(quo_nxt) : quo_nxt;
      SEL_REM: result = neg_rem_p0 ? neg_w(rem_nxt) : rem_nxt;
      default: result = '0;
    endcase
  end

  assign done = busy && (cnt == CW'(XLEN - 1));

  // Step counter; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if (done) busy <= 1'b0;
      cnt <= cnt + 1'b1;
    end
  end

  // Datapath: load magnitudes on start, advance one bit per busy cycle.
  always_ff @(posedge clk) begin
    if (start) begin
      prod_p0    <= {{XLEN{1'b0}}, a_mag};
      mcand_p0   <= b_mag;
      rem_p0     <= '0;
      quo_p0     <= a_mag;
      dvs_p0     <= b_mag;
      neg_res_p0 <= a_sgn ^ b_sgn;
      neg_rem_p0 <= a_sgn;
      sel_p0     <= sel_c;
    end else if (busy) begin
      prod_p0 <= prod_nxt;
      rem_p0  <= rem_nxt;
      quo_p0  <= quo_nxt;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Single-issue ALU with optional multiply/divide group behind a
// valid/ready handshake. Basic ops, illegal opcodes and the divide corner
// cases resolve in one cycle; the remaining MUL*/DIV*/REM* ops go to the
// bit-serial engine and take XLEN cycles.
// Build macro ALU_MULDIV_M_EN: when defined, opcodes 0x10..0x17 are
// implemented; when undefined they decode as illegal and no engine exists.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  alu_muldiv_if.slave bus
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e state, state_nxt;

  logic            in_ready;
  logic            out_valid;
  logic            accept;
  logic            lt_c;
  logic            ill_c;
  logic            iter_op;
  logic [XLEN-1:0] res_c;
  logic            iter_done;
  logic [XLEN-1:0] iter_res;

  logic [XLEN-1:0] alu_out_p0;
  logic            less_p0;
  logic            illegal_p0;

  function automatic logic [XLEN-1:0] basic_result(input logic [4:0] op,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        r;
    a_s = a;
    b_s = b;
    sh  = b[SHW-1:0];
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = a_s >>> sh;
      OP_SLL:  r = a << sh;
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_basic(input logic [4:0] op);
    return (op[4] == 1'b0) && (op[3:0] <= 4'd9);
  endfunction

  assign in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign out_valid = (state == DONE);
  assign accept    = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.ALUOut    = alu_out_p0;
  assign bus.Zero      = out_valid && (alu_out_p0 == '0);
  assign bus.less      = less_p0;
  assign bus.illegal   = illegal_p0;

  // Decode: single-cycle result, or hand-off to the iterative engine.
  always_comb begin
    lt_c    = (bus.ALUControl == OP_SLT) ? ($signed(bus.A) < $signed(bus.B))
                                         : (bus.A < bus.B);
    res_c   = '0;
    ill_c   = 1'b0;
    iter_op = 1'b0;
    if (is_muldiv(bus.ALUControl)) begin
`ifdef ALU_MULDIV_M_EN
      case (bus.ALUControl)
        OP_DIV: begin
          if (bus.B == '0)                          res_c = '1;
          else if (bus.A == SMIN && bus.B == '1)    res_c = SMIN;
          else                                      iter_op = 1'b1;
        end
        OP_DIVU: begin
          if (bus.B == '0) res_c = '1;
          else             iter_op = 1'b1;
        end
        OP_REM: begin
          if (bus.B == '0)                          res_c = bus.A;
          else if (bus.A == SMIN && bus.B == '1)    res_c = '0;
          else                                      iter_op = 1'b1;
        end
        OP_REMU: begin
          if (bus.B == '0) res_c = bus.A;
          else             iter_op = 1'b1;
        end
        default: iter_op = 1'b1;
      endcase
`else
      ill_c = 1'b1;
`endif
    end else if (is_basic(bus.ALUControl)) begin
      res_c = basic_result(bus.ALUControl, bus.A, bus.B);
    end else begin
      ill_c = 1'b1;
    end
  end

`ifdef ALU_MULDIV_M_EN
  alu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && iter_op),
    .op     (bus.ALUControl),
    .a      (bus.A),
    .b      (bus.B),
    .done   (iter_done),
    .result (iter_res)
  );
`else
  assign iter_done = 1'b0;
  assign iter_res  = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: a same-cycle accept in DONE takes priority over retiring.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = iter_op ? BUSY : DONE;
      BUSY: if (iter_done) state_nxt = DONE;
      DONE: begin
        if (accept)             state_nxt = iter_op ? BUSY : DONE;
        else if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result register: written only on accept or engine completion, so it
  // holds while a result waits for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_p0 <= '0;
      less_p0    <= 1'b0;
      illegal_p0 <= 1'b0;
    end else if (accept) begin
      less_p0 <= lt_c;
      if (!iter_op) begin
        alu_out_p0 <= res_c;
        illegal_p0 <= ill_c;
      end else begin
        illegal_p0 <= 1'b0;
      end
    end else if (iter_done) begin
      alu_out_p0 <= iter_res;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized bench for alu_muldiv (XLEN=32) with a transaction-level
// reference model and a per-cycle compare process.
module tb_alu_muldiv;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_muldiv_if #(.XLEN(XLEN)) bus();

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] res;
    bit          ill;
    bit          lt;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  bit   was_rst = 1'b0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: result, illegal flag, less flag and cycles from accept to out_valid.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit ill, output bit lt,
                                output int lat);
    int          sai, sbi, qv;
    longint      sp;
    longint unsigned up;
    logic [63:0] pv;
    logic [4:0]  sh;
    sai = a;
    sbi = b;
    sh  = b[4:0];
    lt  = (op == 5'h05) ? (sai < sbi) : (a < b);
    ill = 1'b0;
    lat = 1;
    r   = 32'h0;
    case (op)
      5'h00: r = a + b;
      5'h01: r = a - b;
      5'h02: r = a & b;
      5'h03: r = a | b;
      5'h04: r = a ^ b;
      5'h05: r = (sai < sbi) ? 32'd1 : 32'd0;
      5'h06: r = a >> sh;
      5'h07: r = sai >>> sh;
      5'h08: r = a << sh;
      5'h09: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_M_EN
      5'h10: begin up = longint'(a) * longint'(b); pv = up; r = pv[31:0]; lat = XLEN + 1; end
      5'h11: begin sp = longint'(sai) * longint'(sbi); pv = sp; r = pv[63:32]; lat = XLEN + 1; end
      5'h12: begin sp = longint'(sai) * longint'(b); pv = sp; r = pv[63:32]; lat = XLEN + 1; end
      5'h13: begin up = longint'(a) * longint'(b); pv = up; r = pv[63:32]; lat = XLEN + 1; end
      5'h14: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin qv = sai / sbi; r = qv; lat = XLEN + 1; end
      end
      5'h15: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin r = a / b; lat = XLEN + 1; end
      end
      5'h16: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin qv = sai % sbi; r = qv; lat = XLEN + 1; end
      end
      5'h17: begin
        if (b == 0) r = a;
        else begin r = a % b; lat = XLEN + 1; end
      end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer back-pressure: 0 always ready, 1 never ready, else random.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Compare process: every cycle, DUT outputs against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] mr;
    bit          mi, ml, exp_v;
    int          mlat;
    exp_t        e;
    if (rst) begin
      q.delete();
      was_rst = 1'b1;
    end else begin
      if (was_rst) begin
        chk32("reset_aluout", bus.ALUOut, 32'h0);
        chkb("reset_zero", bus.Zero, 1'b0);
        chkb("reset_less", bus.less, 1'b0);
        chkb("reset_illegal", bus.illegal, 1'b0);
        chkb("reset_out_valid", bus.out_valid, 1'b0);
        chkb("reset_in_ready", bus.in_ready, 1'b1);
        was_rst = 1'b0;
      end
      exp_v = (q.size() > 0) && (cyc >= q[0].due);
      chkb("out_valid", bus.out_valid, exp_v);
      chkb("in_ready", bus.in_ready, (q.size() == 0) || (exp_v && bus.out_ready));
      if (exp_v && bus.out_valid) begin
        e = q[0];
        chk32("aluout", bus.ALUOut, e.res);
        chkb("zero", bus.Zero, e.res == 32'h0);
        chkb("less", bus.less, e.lt);
        chkb("illegal", bus.illegal, e.ill);
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        model(bus.ALUControl, bus.A, bus.B, mr, mi, ml, mlat);
        e.res = mr;
        e.ill = mi;
        e.lt  = ml;
        e.due = cyc + mlat;
        q.push_back(e);
      end
    end
  end

  // Present one request and hold it until accepted; operands are scrambled afterwards.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    bus.ALUControl = op;
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: got no in_ready, want in_ready within 200 cycles (op 0x%02h)", op);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.A = $urandom;
      bus.B = $urandom;
      bus.ALUControl = 5'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 9));
      4:       return 32'h0 - 32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] ops [20] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                           5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h1F, 5'h0C};

  initial begin
    logic [31:0] r;
    bit          il, lt;
    int          lat, n;
    bus.in_valid = 1'b0;
    bus.ALUControl = 5'h0;
    bus.A = 32'h0;
    bus.B = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed pins on the reference model.
    model(5'h00, 32'd10, 32'd5, r, il, lt, lat);
    chk32("pin_add", r, 32'd15); chkb("pin_add_less", lt, 1'b0); chk32("pin_add_lat", 32'(lat), 32'd1);
    model(5'h05, 32'hFFFF_FFFD, 32'd5, r, il, lt, lat);
    chk32("pin_slt", r, 32'd1); chkb("pin_slt_less", lt, 1'b1);
    model(5'h09, 32'hFFFF_FFFD, 32'd5, r, il, lt, lat);
    chk32("pin_sltu", r, 32'd0); chkb("pin_sltu_less", lt, 1'b0);
    model(5'h1F, 32'd1, 32'd2, r, il, lt, lat);
    chkb("pin_ill1f", il, 1'b1); chk32("pin_ill1f_res", r, 32'h0);
`ifdef ALU_MULDIV_M_EN
    model(5'h10, 32'hFFFF_FFFF, 32'd2, r, il, lt, lat);
    chk32("pin_mul", r, 32'hFFFF_FFFE); chk32("pin_mul_lat", 32'(lat), 32'd33);
    model(5'h13, 32'hFFFF_FFFF, 32'd2, r, il, lt, lat);
    chk32("pin_mulhu", r, 32'd1);
    model(5'h11, 32'hFFFF_FFFF, 32'd2, r, il, lt, lat);
    chk32("pin_mulh", r, 32'hFFFF_FFFF);
    model(5'h14, 32'hFFFF_FFF9, 32'd2, r, il, lt, lat);
    chk32("pin_div", r, 32'hFFFF_FFFD);
    model(5'h16, 32'hFFFF_FFF9, 32'd2, r, il, lt, lat);
    chk32("pin_rem", r, 32'hFFFF_FFFF);
    model(5'h15, 32'd5, 32'd0, r, il, lt, lat);
    chk32("pin_divu0", r, 32'hFFFF_FFFF); chk32("pin_divu0_lat", 32'(lat), 32'd1);
    model(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, r, il, lt, lat);
    chk32("pin_div_ovf", r, 32'h8000_0000); chk32("pin_div_ovf_lat", 32'(lat), 32'd1);
`else
    model(5'h10, 32'd3, 32'd4, r, il, lt, lat);
    chkb("pin_mul_ill", il, 1'b1); chk32("pin_mul_res", r, 32'h0); chk32("pin_mul_lat", 32'(lat), 32'd1);
`endif

    // Directed operations through the DUT.
    ready_mode = 0;
    issue(5'h00, 32'd10, 32'd5);
    issue(5'h05, 32'hFFFF_FFFD, 32'd5);
    issue(5'h09, 32'hFFFF_FFFD, 32'd5);
    issue(5'h07, 32'h8000_0010, 32'h0000_0124);
    issue(5'h10, 32'hFFFF_FFFF, 32'd2);
    issue(5'h13, 32'hFFFF_FFFF, 32'd2);
    issue(5'h11, 32'hFFFF_FFFF, 32'd2);
    issue(5'h14, 32'hFFFF_FFF9, 32'd2);
    issue(5'h16, 32'hFFFF_FFF9, 32'd2);
    issue(5'h15, 32'd5, 32'd0);
    issue(5'h14, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(5'h10, 32'd3, 32'd4);
    issue(5'h1F, 32'd3, 32'd4);
    idle(40);

    // Result held under back-pressure.
    ready_mode = 1;
    @(posedge clk);
    #2;
    issue(5'h00, 32'd7, 32'd8);
    repeat (5) begin
      @(negedge clk);
      chkb("hold_out_valid", bus.out_valid, 1'b1);
      chk32("hold_aluout", bus.ALUOut, 32'd15);
      chkb("hold_in_ready", bus.in_ready, 1'b0);
    end
    ready_mode = 0;
    idle(3);

    // Reset while a multiply is outstanding: nothing may be emitted.
    ready_mode = 1;
    @(posedge clk);
    #2;
    issue(5'h10, 32'hFFFF_FFFF, 32'd2);
    idle(9);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    chkb("abandon_out_valid", bus.out_valid, 1'b0);
    chkb("abandon_in_ready", bus.in_ready, 1'b1);
    idle(40);

    // Random traffic with random back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      issue(ops[$urandom_range(0, 19)], rnd_opnd(), rnd_opnd());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    ready_mode = 0;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, want 0", q.size());
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got no finish, want finish before 60000 cycles");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL support 32 and 64.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operation request; in_ready  output  1  block can accept.
REQ-005 ALUControl  input  5  opcode; A, B  input  XLEN  operands.
REQ-006 ALUOut  output  XLEN  registered result; Zero  output  1  ALUOut==0; less  output  1  compare flag.
REQ-007 illegal  output  1  opcode unsupported; out_valid  output  1  result valid; out_ready  input  1  consumer accepts.

Function
REQ-008 Opcodes SHALL be: 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 SLT, 0x06 SRL, 0x07 SRA, 0x08 SLL, 0x09 SLTU, 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU, 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU; all others illegal.
REQ-009 Shifts SHALL use only B[$clog2(XLEN)-1:0]; SRA sign-fills.
REQ-010 less SHALL be signed A<B for SLT, unsigned A<B for every other opcode, captured with the operands.
REQ-011 Accept occurs in cycle T when in_valid && in_ready; operands and opcode SHALL be registered at T and ignored afterwards.
REQ-012 FSM states IDLE, BUSY, DONE; IDLE->DONE on accept of basic, illegal or fast-path op; IDLE->BUSY on accept of MUL*/DIV*/REM*; BUSY->DONE after XLEN iterations; DONE->IDLE when out_ready and no same-cycle accept.
REQ-013 Basic, illegal and fast-path ops SHALL assert out_valid at T+1; iterative ops at T+XLEN+1.
REQ-014 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready), allowing back-to-back throughput for basic ops.
REQ-015 While out_valid && !out_ready, ALUOut, Zero, less, illegal SHALL hold stable.
REQ-016 MUL SHALL return low XLEN bits; MULH/MULHSU/MULHU SHALL return high XLEN bits of the 2*XLEN product with signed*signed, signed*unsigned, unsigned*unsigned operands.
REQ-017 Division SHALL truncate toward zero; remainder sign follows dividend.
REQ-018 Fast path: B==0 -> DIV/DIVU result all-ones, REM/REMU result A; signed A==min and B==-1 -> DIV result min, REM result 0.
REQ-019 Illegal opcode SHALL produce ALUOut=0, Zero=1, illegal=1.
REQ-020 Zero SHALL be derived from the registered ALUOut.

Reset
REQ-021 rst SHALL force state IDLE, ALUOut=0, Zero=0, less=0, illegal=0, out_valid=0 at the next edge.
REQ-022 rst during BUSY or DONE SHALL abandon the operation; no result SHALL be emitted for it.
REQ-023 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-024 Macro ALU_MULDIV_M_EN defined: opcodes 0x10-0x17 SHALL be implemented per REQ-016..018.
REQ-025 Macro undefined: iterative unit SHALL not be instantiated; opcodes 0x10-0x17 SHALL be treated as illegal with T+1 latency; state BUSY SHALL be unreachable.

Structure
REQ-026 Package alu_pkg SHALL hold the opcode enum, FSM state enum and an is_muldiv() helper function.
REQ-027 Sub-module alu_muldiv_iter SHALL hold the shift-add multiplier and restoring divider, one bit per cycle, with start/done strobes.
REQ-028 Basic ops SHALL be combinational inside alu_muldiv ahead of the result register.

Verification
REQ-029 XLEN=32, ADD A=10 B=5 -> out_valid at T+1, ALUOut=15, Zero=0, less=0.
REQ-030 SLT A=-3 B=5 -> ALUOut=1, less=1; SLTU same operands -> ALUOut=0, less=0, Zero=1.
REQ-031 MUL A=0xFFFFFFFF B=2 -> 0xFFFFFFFE at T+33; MULHU same -> 1; MULH same -> 0xFFFFFFFF.
REQ-032 DIV A=-7 B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU A=5 B=0 -> 0xFFFFFFFF at T+1; DIV A=0x80000000 B=-1 -> 0x80000000 at T+1.
REQ-033 out_ready low 5 cycles after ADD -> outputs stable, in_ready=0; rst at T+10 of MUL -> out_valid=0 and in_ready=1 after rst deasserts, no result emitted.
REQ-034 ALU_MULDIV_M_EN undefined: MUL A=3 B=4 -> illegal=1, ALUOut=0, Zero=1 at T+1; opcode 0x1F -> illegal=1 in both builds.
